// File: rtl/cache_mem_responder_if.sv
// Cache-line to backing-memory bus: request inputs, read data return, memory command and error flags.
// slave = responder view, master = cache/memory environment view.
interface cache_mem_responder_if #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_in;
    logic                mem_wrreq;
    logic                mem_rdreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic                cache_line_pause;
    logic [ADDRBITS-1:0] ext_addr;
    logic [DATABITS-1:0] ext_wdata;
    logic                ext_we;
    logic                ext_req;
    logic                ext_ack;
    logic [DATABITS-1:0] ext_rdata;
    logic                ext_rvalid;
    logic                err_overflow;
    logic                err_proto;

    modport slave (
        input  mem_addr, mem_in, mem_wrreq, mem_rdreq, ext_ack, ext_rdata, ext_rvalid,
        output mem_out, mem_out_valid, cache_line_pause,
        output ext_addr, ext_wdata, ext_we, ext_req, err_overflow, err_proto
    );

    modport master (
        output mem_addr, mem_in, mem_wrreq, mem_rdreq, ext_ack, ext_rdata, ext_rvalid,
        input  mem_out, mem_out_valid, cache_line_pause,
        input  ext_addr, ext_wdata, ext_we, ext_req, err_overflow, err_proto
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Queues cache-line requests into a FIFO whose head drives the memory command; read data registered back (1 cycle).
// Latency: enqueue to ext_req 1 cycle; backpressure via registered cache_line_pause, drops on full set err_overflow.
module cache_mem_responder #(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int FIFOBITS    = 3,
    parameter int PAUSEMARGIN = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cache_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << FIFOBITS;
    localparam logic [FIFOBITS:0] FULL_CNT  = (FIFOBITS+1)'(DEPTH);
    localparam logic [FIFOBITS:0] PAUSE_CNT = (FIFOBITS+1)'(DEPTH - PAUSEMARGIN);

    typedef struct packed {
        logic                we;
        logic [ADDRBITS-1:0] addr;
        logic [DATABITS-1:0] data;
    } req_t;

    req_t                fifo_q [DEPTH];
    req_t                fifo_d [DEPTH];
    logic [FIFOBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFOBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFOBITS:0]   count_q, count_d;
    logic                pause_q, pause_d;
    logic [DATABITS-1:0] mem_out_q, mem_out_d;
    logic                mem_out_valid_q, mem_out_valid_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_proto_q, err_proto_d;

    logic push_req, push, pop, empty, full;
    req_t new_req, head;

    // A simultaneous pop frees the slot, so a full FIFO still accepts that cycle.
    always_comb begin
        push_req = bus.mem_wrreq | bus.mem_rdreq;
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop      = ~empty & bus.ext_ack;
        push     = push_req & (~full | pop);
    end

    // Write wins over a concurrent read; the read is dropped and flagged.
    always_comb begin
        new_req.we   = bus.mem_wrreq;
        new_req.addr = bus.mem_addr;
        new_req.data = bus.mem_wrreq ? bus.mem_in : '0;
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = new_req;
            wr_ptr_d         = wr_ptr_q + FIFOBITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFOBITS'(1);
        end
        count_d         = count_q + (FIFOBITS+1)'(push) - (FIFOBITS+1)'(pop);
        pause_d         = (count_d >= PAUSE_CNT);
        err_overflow_d  = err_overflow_q | (push_req & ~push);
        err_proto_d     = err_proto_q | (bus.mem_wrreq & bus.mem_rdreq);
        mem_out_valid_d = bus.ext_rvalid;
        mem_out_d       = bus.ext_rvalid ? bus.ext_rdata : mem_out_q;
    end

    // Storage needs no reset: count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            pause_q         <= 1'b0;
            mem_out_q       <= '0;
            mem_out_valid_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_proto_q     <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            pause_q         <= pause_d;
            mem_out_q       <= mem_out_d;
            mem_out_valid_q <= mem_out_valid_d;
            err_overflow_q  <= err_overflow_d;
            err_proto_q     <= err_proto_d;
        end
    end

    assign head                 = fifo_q[rd_ptr_q];
    assign bus.ext_req          = ~empty;
    assign bus.ext_addr         = head.addr;
    assign bus.ext_wdata        = head.data;
    assign bus.ext_we           = head.we;
    assign bus.mem_out          = mem_out_q;
    assign bus.mem_out_valid    = mem_out_valid_q;
    assign bus.cache_line_pause = pause_q;
    assign bus.err_overflow     = err_overflow_q;
    assign bus.err_proto        = err_proto_q;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: one task per scenario, inline checks, single summary line.
module tb_cache_mem_responder;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    cache_mem_responder_if #(.ADDRBITS(32), .DATABITS(32)) bus ();

    cache_mem_responder #(
        .ADDRBITS(32), .DATABITS(32), .FIFOBITS(3), .PAUSEMARGIN(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_addr   = '0;
        bus.mem_in     = '0;
        bus.mem_wrreq  = 1'b0;
        bus.mem_rdreq  = 1'b0;
        bus.ext_ack    = 1'b0;
        bus.ext_rdata  = '0;
        bus.ext_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        cyc();
        checks++;
        if (bus.ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req got %0h exp 0", bus.ext_req); end
        checks++;
        if (bus.mem_out_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_out_valid got %0h exp 0", bus.mem_out_valid); end
        checks++;
        if (bus.mem_out !== 32'h0) begin errors++; $display("FAIL reset_mem_out got %0h exp 0", bus.mem_out); end
        checks++;
        if (bus.cache_line_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %0h exp 0", bus.cache_line_pause); end
        checks++;
        if ({bus.err_overflow, bus.err_proto} !== 2'b00) begin
            errors++; $display("FAIL reset_errs got %0b exp 00", {bus.err_overflow, bus.err_proto});
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        do_reset();
        bus.ext_ack = 1'b1;
        for (int i = 0; i < 31; i++) begin
            exp_addr      = 32'h1000 + 32'(i) * 4;
            bus.mem_rdreq = 1'b1;
            bus.mem_addr  = exp_addr;
            cyc();
            checks++;
            if (bus.ext_req !== 1'b1 || bus.ext_addr !== exp_addr || bus.ext_we !== 1'b0) begin
                errors++;
                $display("FAIL stream_head[%0d] got req=%0h addr=%0h we=%0h exp req=1 addr=%0h we=0",
                         i, bus.ext_req, bus.ext_addr, bus.ext_we, exp_addr);
            end
            checks++;
            if (bus.cache_line_pause !== 1'b0) begin errors++; $display("FAIL stream_pause[%0d] got %0h exp 0", i, bus.cache_line_pause); end
        end
        bus.mem_rdreq = 1'b0;
        cyc();
        checks++;
        if (bus.ext_req !== 1'b0) begin errors++; $display("FAIL stream_drained got %0h exp 0", bus.ext_req); end
        checks++;
        if ({bus.err_overflow, bus.err_proto} !== 2'b00) begin
            errors++; $display("FAIL stream_errs got %0b exp 00", {bus.err_overflow, bus.err_proto});
        end
        bus.ext_ack = 1'b0;
    endtask

    task automatic test_rdata();
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata  = 32'hDEADBEEF;
        cyc();
        bus.ext_rvalid = 1'b0;
        bus.ext_rdata  = 32'h12345678;
        checks++;
        if (bus.mem_out_valid !== 1'b1 || bus.mem_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rdata_valid got v=%0h d=%0h exp v=1 d=deadbeef", bus.mem_out_valid, bus.mem_out);
        end
        cyc();
        checks++;
        if (bus.mem_out_valid !== 1'b0 || bus.mem_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rdata_hold got v=%0h d=%0h exp v=0 d=deadbeef", bus.mem_out_valid, bus.mem_out);
        end
    endtask

    task automatic test_proto();
        do_reset();
        bus.mem_rdreq = 1'b1;
        bus.mem_wrreq = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_in    = 32'h5;
        cyc();
        bus.mem_rdreq = 1'b0;
        bus.mem_wrreq = 1'b0;
        checks++;
        if (bus.ext_req !== 1'b1 || bus.ext_we !== 1'b1 || bus.ext_addr !== 32'h40 || bus.ext_wdata !== 32'h5) begin
            errors++;
            $display("FAIL proto_entry got req=%0h we=%0h addr=%0h data=%0h exp 1 1 40 5",
                     bus.ext_req, bus.ext_we, bus.ext_addr, bus.ext_wdata);
        end
        checks++;
        if (bus.err_proto !== 1'b1) begin errors++; $display("FAIL proto_flag got %0h exp 1", bus.err_proto); end
        bus.ext_ack = 1'b1;
        cyc();
        bus.ext_ack = 1'b0;
        checks++;
        if (bus.ext_req !== 1'b0) begin errors++; $display("FAIL proto_single got req=%0h exp 0", bus.ext_req); end
        checks++;
        if (bus.err_proto !== 1'b1 || bus.err_overflow !== 1'b0) begin
            errors++; $display("FAIL proto_sticky got proto=%0h ovf=%0h exp 1 0", bus.err_proto, bus.err_overflow);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        bus.ext_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_wrreq = 1'b1;
            bus.mem_addr  = 32'h200 + 32'(i) * 4;
            bus.mem_in    = 32'h100 + 32'(i);
            cyc();
            if (i == 4 || i == 5) begin
                checks++;
                if (bus.cache_line_pause !== (i == 5)) begin
                    errors++; $display("FAIL fill_pause[%0d] got %0h exp %0h", i, bus.cache_line_pause, (i == 5));
                end
            end
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %0h exp 0", bus.err_overflow); end
        bus.mem_addr = 32'h999;
        bus.mem_in   = 32'h999;
        cyc();
        bus.mem_wrreq = 1'b0;
        checks++;
        if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", bus.err_overflow); end
        checks++;
        if (bus.ext_addr !== 32'h200 || bus.ext_wdata !== 32'h100 || bus.ext_we !== 1'b1) begin
            errors++; $display("FAIL ovf_head got addr=%0h data=%0h exp 200 100", bus.ext_addr, bus.ext_wdata);
        end
        bus.ext_ack = 1'b1;
        cyc();
        for (int j = 1; j < 8; j++) begin
            checks++;
            if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h200 + 32'(j) * 4 || bus.ext_wdata !== 32'h100 + 32'(j)) begin
                errors++;
                $display("FAIL ovf_drain[%0d] got req=%0h addr=%0h data=%0h exp 1 %0h %0h",
                         j, bus.ext_req, bus.ext_addr, bus.ext_wdata, 32'h200 + 32'(j) * 4, 32'h100 + 32'(j));
            end
            cyc();
        end
        bus.ext_ack = 1'b0;
        checks++;
        if (bus.ext_req !== 1'b0 || bus.cache_line_pause !== 1'b0 || bus.err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end got req=%0h pause=%0h ovf=%0h exp 0 0 1", bus.ext_req, bus.cache_line_pause, bus.err_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.mem_wrreq = 1'b1;
            bus.mem_addr  = 32'h500 + 32'(i) * 4;
            bus.mem_in    = 32'hA0 + 32'(i);
            cyc();
        end
        bus.mem_addr = 32'h600;
        bus.mem_in   = 32'hBB;
        bus.ext_ack  = 1'b1;
        cyc();
        bus.mem_wrreq = 1'b0;
        bus.ext_ack   = 1'b0;
        checks++;
        if (bus.err_overflow !== 1'b0 || bus.ext_addr !== 32'h504 || bus.cache_line_pause !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_state got ovf=%0h addr=%0h pause=%0h exp 0 504 1", bus.err_overflow, bus.ext_addr, bus.cache_line_pause);
        end
        bus.ext_ack = 1'b1;
        for (int j = 1; j < 8; j++) begin
            cyc();
            checks++;
            if (bus.ext_addr !== ((j == 7) ? 32'h600 : 32'h500 + 32'(j + 1) * 4)) begin
                errors++; $display("FAIL fullpp_drain[%0d] got addr=%0h", j, bus.ext_addr);
            end
        end
        checks++;
        if (bus.ext_wdata !== 32'hBB || bus.ext_req !== 1'b1) begin
            errors++; $display("FAIL fullpp_last got data=%0h req=%0h exp bb 1", bus.ext_wdata, bus.ext_req);
        end
        cyc();
        bus.ext_ack = 1'b0;
        checks++;
        if (bus.ext_req !== 1'b0) begin errors++; $display("FAIL fullpp_empty got %0h exp 0", bus.ext_req); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mem_rdreq = 1'b1;
        bus.mem_wrreq = 1'b1;
        bus.mem_addr  = 32'h700;
        bus.mem_in    = 32'h1;
        cyc();
        bus.mem_rdreq = 1'b0;
        for (int i = 1; i < 5; i++) begin
            bus.mem_addr = 32'h700 + 32'(i) * 4;
            cyc();
        end
        bus.mem_wrreq = 1'b0;
        checks++;
        if (bus.ext_req !== 1'b1 || bus.err_proto !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got req=%0h proto=%0h exp 1 1", bus.ext_req, bus.err_proto);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ext_req !== 1'b0 || bus.err_proto !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got req=%0h proto=%0h exp 0 0", bus.ext_req, bus.err_proto);
        end
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({bus.ext_req, bus.cache_line_pause, bus.err_overflow, bus.err_proto, bus.mem_out_valid} !== 5'b0) begin
                errors++;
                $display("FAIL rstmid_after[%0d] got req=%0h pause=%0h ovf=%0h proto=%0h vld=%0h exp all 0",
                         k, bus.ext_req, bus.cache_line_pause, bus.err_overflow, bus.err_proto, bus.mem_out_valid);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_rdata();
        test_proto();
        test_fill_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
